imem_loader: RTL

Boot-time programming engine for the byte-addressed, little-endian 128 KiB instruction memory. It accepts a framed byte stream (from the UART receiver or a debug bridge), packs it into 32-bit little-endian words, and drives the memory's write port. It holds the core in reset while loading, so the core fetches only a complete, checksum-verified image. It is the writer for the fetch-side reader.

---
 rtl/imem_loader_pkg.sv | 12 +
 rtl/imem_loader_pack.sv | 39 +++
 rtl/imem_loader.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and frame constants for the instruction-memory boot loader.
`timescale 1ns/1ps
package imem_loader_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_LEN, ST_DATA, ST_CSUM, ST_DONE, ST_ERR
  } state_t;

  localparam int MEM_BYTES_DEF = 131072;
  localparam int LEN_BYTES     = 4;
  localparam int CSUM_BYTES    = 1;
  localparam int NUM_LANES     = 4;
endpackage

// File: rtl/imem_loader_pack.sv
// Byte-to-word packer: collects bytes into lanes; word/strb include the byte being accepted now.
`timescale 1ns/1ps
module imem_loader_pack #(
  parameter int NUM_LANES = 4,
  localparam int LW = $clog2(NUM_LANES)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [7:0]                  byte_i,
  input  logic [LW-1:0]               lane_i,
  input  logic                        valid_i,
  input  logic                        flush_i,
  output logic [NUM_LANES-1:0][7:0]   word_o,
  output logic [NUM_LANES-1:0]        strb_o
);
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [7:0] lane_q;
    logic       strb_q;
    logic       hit;

    assign hit       = valid_i && (lane_i == LW'(g));
    assign word_o[g] = hit ? byte_i : lane_q;
    assign strb_o[g] = hit | strb_q;

    // Flush clears the lane so a short tail word carries zeros in unreceived lanes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        lane_q <= '0;
        strb_q <= 1'b0;
      end else if (flush_i) begin
        lane_q <= '0;
        strb_q <= 1'b0;
      end else if (hit) begin
        lane_q <= byte_i;
        strb_q <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Framed-stream boot loader: length header, payload packed into LE words, checksum gate on core release.
`timescale 1ns/1ps
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          MEM_BYTES = MEM_BYTES_DEF,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic        wr_en_o,
  output logic [31:0] wr_addr_o,
  output logic [31:0] wr_data_o,
  output logic [3:0]  wr_strb_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        core_hold_o
);
  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d, len_q, len_d;
  logic [7:0]  acc_q, acc_d;
  logic        done_d, err_d, hold_d, rdy_d;
  logic        fire, pk_valid, flush;
  logic [NUM_LANES-1:0][7:0] pk_word;
  logic [NUM_LANES-1:0]      pk_strb;

  assign fire = rx_valid_i && rx_ready_o;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    acc_d    = acc_q;
    done_d   = done_o;
    err_d    = err_o;
    hold_d   = core_hold_o;
    pk_valid = 1'b0;
    flush    = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_i) begin
          state_d = ST_LEN;
          cnt_d   = '0;
          len_d   = '0;
          acc_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          hold_d  = 1'b1;
        end
      end
      ST_LEN: begin
        if (fire) begin
          len_d = {rx_data_i, len_q[31:8]};
          cnt_d = cnt_q + 32'd1;
          if (cnt_q == 32'(LEN_BYTES - 1)) begin
            cnt_d = '0;
            if (len_d > 32'(MEM_BYTES)) begin
              state_d = ST_ERR;
              err_d   = 1'b1;
            end else if (len_d == '0) begin
              state_d = ST_CSUM;
            end else begin
              state_d = ST_DATA;
            end
          end
        end
      end
      ST_DATA: begin
        if (fire) begin
          pk_valid = 1'b1;
          acc_d    = acc_q + rx_data_i;
          cnt_d    = cnt_q + 32'd1;
          if (cnt_q[1:0] == 2'd3 || cnt_d == len_q) flush = 1'b1;
          if (cnt_d == len_q) begin
            state_d = ST_CSUM;
            cnt_d   = '0;
          end
        end
      end
      ST_CSUM: begin
        if (fire && cnt_q == 32'(CSUM_BYTES - 1)) begin
          if (rx_data_i == acc_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    rdy_d = (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_CSUM);
  end

  imem_loader_pack #(.NUM_LANES(NUM_LANES)) u_pack (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .byte_i  (rx_data_i),
    .lane_i  (cnt_q[1:0]),
    .valid_i (pk_valid),
    .flush_i (flush),
    .word_o  (pk_word),
    .strb_o  (pk_strb)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      acc_q       <= '0;
      rx_ready_o  <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      core_hold_o <= 1'b0;
      wr_en_o     <= 1'b0;
      wr_addr_o   <= '0;
      wr_data_o   <= '0;
      wr_strb_o   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      acc_q       <= acc_d;
      rx_ready_o  <= rdy_d;
      busy_o      <= rdy_d;
      done_o      <= done_d;
      err_o       <= err_d;
      core_hold_o <= hold_d;
      wr_en_o     <= flush;
      // Address uses the pre-increment count so it names the word just completed.
      if (flush) begin
        wr_addr_o <= BASE_ADDR + {cnt_q[31:2], 2'b00};
        wr_data_o <= pk_word;
        wr_strb_o <= pk_strb;
      end
    end
  end
endmodule
